// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] OP_MULDIV     = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: UNROLL iterations of unsigned shift-add multiply or restoring
// divide on a {hi, lo} pair. Multiply: hi accumulates, lo holds the multiplier
// and receives product bits. Divide: hi is the partial remainder, lo shifts
// the dividend out and the quotient in.
module muldiv_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_nx,
  output logic [XLEN-1:0] lo_nx
);

  logic [XLEN-1:0] h;
  logic [XLEN-1:0] l;
  logic [XLEN:0]   sum;

  // Unrolled chain of single-bit steps; sum is XLEN+1 wide to keep the carry/borrow.
  always_comb begin
    h   = hi;
    l   = lo;
    sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        sum = {h, l[XLEN-1]};
        l   = {l[XLEN-2:0], 1'b0};
        if (sum >= {1'b0, b}) begin
          sum  = sum - {1'b0, b};
          l[0] = 1'b1;
        end
        h = sum[XLEN-1:0];
      end else begin
        sum = {1'b0, h} + (l[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
        l   = {sum[0], l[XLEN-1:1]};
        h   = sum[XLEN:1];
      end
    end
    hi_nx = h;
    lo_nx = l;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide with start/done handshake
// and flush abort. Build option MULDIV_FAST_MUL_EN: MUL* ops use one registered
// 2*XLEN multiplier and finish straight from IDLE; divides stay iterative.
//
// state   | meaning
// MD_IDLE | waiting for start
// MD_CALC | iterating XLEN/UNROLL steps, busy=1
// MD_DONE | result just registered, done=1 for one cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              STEPS    = XLEN / UNROLL;
  localparam int              CW       = $clog2(STEPS) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(STEPS);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_nx;
  logic            accept, step_en, last_step;
  logic [2:0]      f3_q;
  logic            neg_a_q, neg_b_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;
  logic [CW-1:0]   cnt_q;

  logic            a_signed, b_signed, neg_a_in, neg_b_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic            direct_go;
  logic [XLEN-1:0] direct_val;

  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  // Start-edge decode: operand signedness, magnitudes and single-cycle outcomes.
  always_comb begin
    a_signed = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH) ||
               (funct3 == FUNCT3_MULHSU) || (funct3 == FUNCT3_DIV) ||
               (funct3 == FUNCT3_REM);
    b_signed = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH) ||
               (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    neg_a_in = a_signed & op_a[XLEN-1];
    neg_b_in = b_signed & op_b[XLEN-1];
    mag_a_in = neg_a_in ? -op_a : op_a;
    mag_b_in = neg_b_in ? -op_b : op_b;
    div_by_zero = funct3[2] && (op_b == '0);
    div_ovf     = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    special_res = '0;
    if (div_by_zero) special_res = funct3[1] ? op_a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : op_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_prod_s;
  logic              fast_mul;

  // Whole product in one cycle from the start-edge magnitudes.
  always_comb begin
    fast_prod   = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
    fast_prod_s = (neg_a_in ^ neg_b_in) ? -fast_prod : fast_prod;
    fast_mul    = !funct3[2];
    direct_go   = div_by_zero | div_ovf | fast_mul;
    if (!fast_mul) direct_val = special_res;
    else if (funct3 == FUNCT3_MUL) direct_val = fast_prod_s[XLEN-1:0];
    else direct_val = fast_prod_s[2*XLEN-1:XLEN];
  end
`else
  // Only the divide special cases bypass the iteration.
  always_comb begin
    direct_go  = div_by_zero | div_ovf;
    direct_val = special_res;
  end
`endif

  muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div (f3_q[2]),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_nx  (hi_nx),
    .lo_nx  (lo_nx)
  );

  // Sign correction and result selection on the final step's outputs.
  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_s  = (neg_a_q ^ neg_b_q) ? -lo_nx : lo_nx;
    rem_s  = neg_a_q ? -hi_nx : hi_nx;
    if (f3_q[2]) final_res = f3_q[1] ? rem_s : quo_s;
    else if (f3_q == FUNCT3_MUL) final_res = prod_s[XLEN-1:0];
    else final_res = prod_s[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else state_q <= state_nx;
  end

  // Next state and handshake; flush overrides any start or step.
  always_comb begin
    state_nx  = state_q;
    accept    = 1'b0;
    step_en   = 1'b0;
    last_step = 1'b0;
    busy      = (state_q == MD_CALC);
    done      = (state_q == MD_DONE);
    if (flush) begin
      state_nx = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          state_nx = MD_IDLE;
          if (start) begin
            accept   = 1'b1;
            state_nx = direct_go ? MD_DONE : MD_CALC;
          end
        end
        MD_CALC: begin
          step_en = 1'b1;
          if (cnt_q == CW'(1)) begin
            last_step = 1'b1;
            state_nx  = MD_DONE;
          end
        end
        default: state_nx = MD_IDLE;
      endcase
    end
  end

  // Datapath: operand capture on accept, one step per CALC cycle, result write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      f3_q    <= funct3;
      neg_a_q <= neg_a_in;
      neg_b_q <= neg_b_in;
      hi_q    <= '0;
      lo_q    <= mag_a_in;
      b_q     <= mag_b_in;
      cnt_q   <= CNT_LOAD;
      if (direct_go) result_q <= direct_val;
    end else if (step_en) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q - CW'(1);
      if (last_step) result_q <= final_res;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: two instances (32/1 and 64/4) checked against an arithmetic
// reference model; latency counted in clock edges including the start edge.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        s32_start = 1'b0, s32_flush = 1'b0;
  logic [2:0]  s32_f3 = '0;
  logic [31:0] s32_a = '0, s32_b = '0;
  logic        d32_busy, d32_done;
  logic [31:0] d32_result;

  logic        s64_start = 1'b0, s64_flush = 1'b0;
  logic [2:0]  s64_f3 = '0;
  logic [63:0] s64_a = '0, s64_b = '0;
  logic        d64_busy, d64_done;
  logic [63:0] d64_result;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last32 = '0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT32 = 1;
`else
  localparam int MUL_LAT32 = 33;
`endif

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32_start), .funct3(s32_f3),
    .op_a(s32_a), .op_b(s32_b), .flush(s32_flush),
    .busy(d32_busy), .done(d32_done), .result(d32_result)
  );

  muldiv_unit #(.XLEN(64), .UNROLL(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(s64_start), .funct3(s64_f3),
    .op_a(s64_a), .op_b(s64_b), .flush(s64_flush),
    .busy(d64_busy), .done(d64_done), .result(d64_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    logic [63:0] mask, am, bm, res;
    logic signed [129:0] sa, sb, p, q, r, one;
    logic a_s, b_s;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am = a & mask;
    bm = b & mask;
    a_s = (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
          (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    b_s = (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    one = 130'sd1;
    sa = $signed({66'd0, am});
    sb = $signed({66'd0, bm});
    if (a_s && am[w-1]) sa = sa - (one <<< w);
    if (b_s && bm[w-1]) sb = sb - (one <<< w);
    if (!f3[2]) begin
      p = sa * sb;
      if (f3 == FUNCT3_MUL) res = p[63:0];
      else begin
        p = p >>> w;
        res = p[63:0];
      end
    end else if (bm == 64'd0) begin
      res = f3[1] ? am : mask;
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = f3[1] ? r[63:0] : q[63:0];
    end
    return res & mask;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [63:0] a,
                                 input logic [63:0] b, input int w);
    logic [63:0] mask, mn;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn = 64'h1 << (w - 1);
    if (f3[2] && ((b & mask) == 64'd0)) return 1;
    if (((f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM)) && ((a & mask) == mn) && ((b & mask) == mask))
      return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return (w == 64) ? (64 / 4 + 1) : (32 / 1 + 1);
  endfunction

  // Issue one op to the selected instance; lat = edges from start edge to done, -1 on timeout.
  task automatic do_op(input bit wide, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk);
    if (wide) begin
      s64_f3 = f3; s64_a = a; s64_b = b; s64_start = 1'b1;
    end else begin
      s32_f3 = f3; s32_a = a[31:0]; s32_b = b[31:0]; s32_start = 1'b1;
    end
    @(posedge clk); #1;
    s32_start = 1'b0;
    s64_start = 1'b0;
    lat = 1;
    while (!(wide ? d64_done : d32_done) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(wide ? d64_done : d32_done)) lat = -1;
    res = wide ? d64_result : {32'h0, d32_result};
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({d32_busy, d32_done, d32_result} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset32 got busy=%b done=%b result=%h want 0 0 0", d32_busy, d32_done, d32_result);
    end
    n_cmp++;
    if ({d64_busy, d64_done, d64_result} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset64 got busy=%b done=%b result=%h want 0 0 0", d64_busy, d64_done, d64_result);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({d32_busy, d32_done, d32_result} !== 34'h0) begin
      n_fail++;
      $display("FAIL post_reset32 got busy=%b done=%b result=%h want 0 0 0", d32_busy, d32_done, d32_result);
    end
  endtask

  task automatic test_divide;
    logic [2:0]  tf [6] = '{FUNCT3_DIV, FUNCT3_REM, FUNCT3_DIVU, FUNCT3_REMU, FUNCT3_DIV, FUNCT3_REM};
    logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] tv [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] te [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    int          tl [6] = '{33, 33, 1, 1, 1, 1};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, tf[i], {32'h0, ta[i]}, {32'h0, tv[i]}, res, lat);
      n_cmp++;
      if (res[31:0] !== te[i]) begin
        n_fail++;
        $display("FAIL div_result[%0d] got %h want %h", i, res[31:0], te[i]);
      end
      n_cmp++;
      if (lat != tl[i]) begin
        n_fail++;
        $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, tl[i]);
      end
      last32 = te[i];
    end
  endtask

  task automatic test_multiply;
    logic [2:0]  tf [4] = '{FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MUL, FUNCT3_MULHU};
    logic [31:0] ta [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] tv [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] te [4] = '{32'h40000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, tf[i], {32'h0, ta[i]}, {32'h0, tv[i]}, res, lat);
      n_cmp++;
      if (res[31:0] !== te[i]) begin
        n_fail++;
        $display("FAIL mul_result[%0d] got %h want %h", i, res[31:0], te[i]);
      end
      n_cmp++;
      if (lat != MUL_LAT32) begin
        n_fail++;
        $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, MUL_LAT32);
      end
      last32 = te[i];
    end
  endtask

  task automatic test_flush;
    logic seen;
    @(negedge clk);
    s32_f3 = FUNCT3_DIV; s32_a = 32'd100; s32_b = 32'd7; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++;
    if (d32_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy_before got %b want 1", d32_busy);
    end
    @(negedge clk) s32_flush = 1'b1;
    @(posedge clk); #1;
    s32_flush = 1'b0;
    n_cmp++;
    if ({d32_busy, d32_done, d32_result} !== {2'b00, last32}) begin
      n_fail++;
      $display("FAIL flush_abort got busy=%b done=%b result=%h want 0 0 %h", d32_busy, d32_done, d32_result, last32);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (d32_done || d32_busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_done got activity=%b want 0", seen);
    end
    // start with flush in the same cycle: a divide-by-zero would otherwise finish at once
    @(negedge clk);
    s32_f3 = FUNCT3_DIVU; s32_a = 32'd5; s32_b = 32'd0; s32_start = 1'b1; s32_flush = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0; s32_flush = 1'b0;
    n_cmp++;
    if ({d32_busy, d32_done, d32_result} !== {2'b00, last32}) begin
      n_fail++;
      $display("FAIL flush_start got busy=%b done=%b result=%h want 0 0 %h", d32_busy, d32_done, d32_result, last32);
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    s32_f3 = FUNCT3_DIV; s32_a = 32'd100; s32_b = 32'd7; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    lat = -1;
    for (int e = 2; e <= 60; e++) begin
      @(negedge clk);
      if (e == 6) begin
        s32_f3 = FUNCT3_DIVU; s32_a = 32'd5; s32_b = 32'd0; s32_start = 1'b1;
      end
      @(posedge clk); #1;
      s32_start = 1'b0;
      if (d32_done) begin
        lat = e;
        break;
      end
    end
    n_cmp++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL busy_start_latency got %0d want 33", lat);
    end
    n_cmp++;
    if (d32_result !== 32'd14) begin
      n_fail++;
      $display("FAIL busy_start_result got %h want %h", d32_result, 32'd14);
    end
    last32 = 32'd14;
  endtask

  // do_op starts on the negedge following the observed done, i.e. inside the DONE cycle.
  task automatic test_back_to_back;
    logic [63:0] res;
    int lat;
    do_op(1'b0, FUNCT3_DIV, 64'd100, 64'd7, res, lat);
    do_op(1'b0, FUNCT3_REM, 64'd100, 64'd7, res, lat);
    n_cmp++;
    if (res[31:0] !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_result got %h want %h", res[31:0], 32'd2);
    end
    n_cmp++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL b2b_latency got %0d want 33", lat);
    end
    last32 = 32'd2;
  endtask

  task automatic test_random_sweep(input bit wide, input int count);
    logic [63:0] a, b, mask, res, exp;
    logic [2:0] f3;
    int lat, elat, w, r;
    w = wide ? 64 : 32;
    mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < count; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom} & mask;
      b = {$urandom, $urandom} & mask;
      r = $urandom_range(0, 15);
      if (r == 0) b = 64'd0;
      else if (r == 1) begin
        a = 64'h1 << (w - 1);
        b = mask;
      end else if (r < 5) b = b >> $urandom_range(1, w - 1);
      exp = ref_res(f3, a, b, w);
      elat = ref_lat(f3, a, b, w);
      do_op(wide, f3, a, b, res, lat);
      n_cmp++;
      if (res !== exp) begin
        n_fail++;
        $display("FAIL sweep%0d[%0d] f3=%0d a=%h b=%h got %h want %h", w, i, f3, a, b, res, exp);
      end
      n_cmp++;
      if (lat != elat) begin
        n_fail++;
        $display("FAIL sweep%0d_lat[%0d] f3=%0d got %0d want %0d", w, i, f3, lat, elat);
      end
      if (!wide) last32 = exp[31:0];
    end
  endtask

  task automatic test_reset_mid_calc;
    logic seen;
    logic [63:0] res;
    int lat;
    @(negedge clk);
    s32_f3 = FUNCT3_DIVU; s32_a = 32'd1000; s32_b = 32'd3; s32_start = 1'b1;
    s64_f3 = FUNCT3_MULHU; s64_a = 64'hFFFF_0000_1234_5678; s64_b = 64'd3; s64_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0; s64_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (d32_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy32_before got %b want 1", d32_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d32_busy, d32_done, d32_result} !== 34'h0) begin
      n_fail++;
      $display("FAIL midrst32 got busy=%b done=%b result=%h want 0 0 0", d32_busy, d32_done, d32_result);
    end
    n_cmp++;
    if ({d64_busy, d64_done, d64_result} !== 66'h0) begin
      n_fail++;
      $display("FAIL midrst64 got busy=%b done=%b result=%h want 0 0 0", d64_busy, d64_done, d64_result);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (d32_done || d64_done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_done got %b want 0", seen);
    end
    do_op(1'b1, FUNCT3_DIVU, 64'd100, 64'd7, res, lat);
    n_cmp++;
    if (res !== 64'd14 || lat != 17) begin
      n_fail++;
      $display("FAIL midrst_recover got result=%h lat=%0d want %h 17", res, lat, 64'd14);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_multiply();
    test_flush();
    test_start_while_busy();
    test_back_to_back();
    test_random_sweep(1'b0, 100);
    test_random_sweep(1'b1, 1000);
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply-divide unit for the multicycle core.
- Sits beside the ALU. The control FSM holds in EXECUTE while busy, mirroring WAIT_MEM.
- Executes all eight OP_REG/funct7=0000001 operations over XLEN and returns the result with a start/done handshake.
- Supports abort on flush.

Parameters:
- XLEN, 32: operand and result width; 32 or 64.
- UNROLL, 1: quotient/product bits per CALC cycle; power of two dividing XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  accepts an operation; honoured only in IDLE or DONE.
- funct3  in  3  operation select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- op_a  in  XLEN  rs1 value; sampled on the start edge.
- op_b  in  XLEN  rs2 value; sampled on the start edge.
- flush  in  1  aborts the operation in progress.
- busy  out  1  high in CALC.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  XLEN  holds its value until the next accepted start.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, result=0.
  - Internal registers cleared.
  - Asynchronous, so it applies mid-operation and nothing completes.
- States and transitions:
  - IDLE, start: latch operands, funct3, sign flags. Go to CALC, or to DONE directly for a special case.
  - CALC: counter counts XLEN/UNROLL cycles, each step processing UNROLL bits. On the last step apply sign correction and register result, then go to DONE.
  - DONE: done=1 for exactly one cycle. start in that cycle is accepted, same as IDLE. Otherwise go to IDLE.
- Latency:
  - Normal: done asserts XLEN/UNROLL+1 edges after the start edge, i.e. 33 for 32/1.
  - Special cases: 1 edge.
- Multiply:
  - Signed operands are converted to magnitudes per funct3. MULHSU treats op_a signed and op_b unsigned.
  - Unsigned shift-add produces a 2*XLEN product, negated when the signs differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Special cases, which skip CALC:
  - op_b=0: DIV/DIVU give all-ones, REM/REMU give op_a.
  - DIV with op_a=most-negative and op_b=-1: returns op_a. The matching REM returns 0.
- Handshake rules:
  - start while busy is ignored.
  - flush takes priority over everything except reset. In any state it forces IDLE on the next edge, with no done pulse; result is unchanged.
  - flush and start in the same cycle: flush wins and start is dropped.
- Width rules:
  - All internal sums are XLEN+1 wide.
  - The counter is clog2(XLEN/UNROLL)+1 bits and wraps only at reset or a new start.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MUL* ops use a single synthesised 2*XLEN multiplier, registered once.
  - They go IDLE to DONE and done asserts 1 edge after start.
  - Divide path is unchanged.
- Undefined: all ops use the iterative CALC path described above.

Decomposition:
- Add to the shared types package:
  - OP_MULDIV funct7 constant 7'b0000001.
  - FUNCT3_MUL..FUNCT3_REMU localparams (000..111).
  - muldiv_state_t enum {MD_IDLE, MD_CALC, MD_DONE}.
- Sub-module muldiv_step: combinational UNROLL-bit shift-add/restore-subtract step, instantiated once in CALC.

Test Plan (XLEN=32, UNROLL=1 unless noted):
1. DIV op_a=-7, op_b=2 -> done 33 edges after start, result=0xFFFFFFFD. REM of the same operands -> result=0xFFFFFFFF.
2. DIVU op_a=5, op_b=0 -> done 1 edge after start, result=0xFFFFFFFF. REMU op_a=5, op_b=0 -> result=5.
3. DIV op_a=0x80000000, op_b=0xFFFFFFFF -> result=0x80000000. REM of the same -> result=0.
4. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MUL of the same -> 0x00000001. Repeat with MULDIV_FAST_MUL_EN: done after 1 edge.
5. Abort and busy handling:
   - flush 10 cycles into a DIV -> IDLE on the next edge, no done pulse, result unchanged.
   - A start during busy is ignored, and done still arrives at edge 33 of the first operation.
   - Back-to-back start asserted in the DONE cycle -> second op accepted, and its done arrives 33 edges later.
6. UNROLL=4 and XLEN=64 sweep of 1000 random operands against a reference model -> exact match, latency XLEN/UNROLL+1. rst_n pulsed mid-CALC -> busy=0, done=0, result=0 immediately.
